ppg_peak_detector: RTL and testbench

Front-end stage of the MAX30100 vital-sign path. Smooths raw IR/RED samples with a per-channel moving average and runs a hysteretic peak-detection FSM on the smoothed IR channel. Produces `filtered_ir`, `filtered_red`, a `new_sample` strobe and a `peak_detected` strobe for the heart-rate/SpO2 calculation stage directly downstream.

---
 rtl/ppg_pkg.sv | 20 ++
 rtl/ppg_moving_avg.sv | 49 ++++
 rtl/ppg_peak_detector.sv | 146 ++++++++++++++
 tb/tb_ppg_peak_detector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared types and helpers for the PPG front end: detector state encoding,
// default thresholds and the wrap-free signed difference used by the peak FSM.
package ppg_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_RISING  = 2'd1,
    ST_FALLING = 2'd2
  } ppg_state_t;

  localparam int PPG_HYST_DEFAULT    = 16;
  localparam int PPG_REFRACT_DEFAULT = 30;

  // a - b on zero-extended operands; one extra bit keeps the sign exact
  function automatic logic signed [32:0] ppg_sdiff(input logic [31:0] a,
                                                   input logic [31:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

endpackage

// File: rtl/ppg_moving_avg.sv
// Boxcar moving average over the last 2^AVG_LOG2 samples using a shift window
// and a running sum; the output register updates one cycle after in_valid.
module ppg_moving_avg #(
  parameter int DATA_WIDTH = 16,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_WIDTH + AVG_LOG2;

  logic [DATA_WIDTH-1:0] win_r [DEPTH];
  logic [SUM_W-1:0]      sum_r;
  logic [SUM_W-1:0]      sum_nxt_s;

  // Running sum after admitting in_data and retiring the oldest entry
  always_comb begin
    sum_nxt_s = sum_r + SUM_W'(in_data) - SUM_W'(win_r[DEPTH-1]);
  end

  // Window shift, sum and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        win_r[i] <= '0;
      end
      sum_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        win_r[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          win_r[i] <= win_r[i-1];
        end
        sum_r    <= sum_nxt_s;
        out_data <= DATA_WIDTH'(sum_nxt_s >> AVG_LOG2);
      end
    end
  end

endmodule

// File: rtl/ppg_peak_detector.sv
// PPG front end: per-channel moving average followed by a hysteretic peak
// detector with a refractory interval on the smoothed IR channel.
module ppg_peak_detector
  import ppg_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int AVG_LOG2        = 2,
  parameter int HYST            = PPG_HYST_DEFAULT,
  parameter int REFRACT_SAMPLES = PPG_REFRACT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] raw_ir,
  input  logic [DATA_WIDTH-1:0] raw_red,
  output logic                  new_sample,
  output logic [DATA_WIDTH-1:0] filtered_ir,
  output logic [DATA_WIDTH-1:0] filtered_red,
  output logic                  peak_detected,
  output logic [DATA_WIDTH-1:0] peak_value
);

  localparam int RW = $clog2(REFRACT_SAMPLES + 1);
  localparam int WW = AVG_LOG2 + 1;
  localparam logic [RW-1:0]        REFR_MAX  = RW'(REFRACT_SAMPLES);
  localparam logic [RW-1:0]        REFR_ONE  = RW'(1);
  localparam logic [WW-1:0]        WARM_LAST = WW'((1 << AVG_LOG2) - 1);
  localparam logic [WW-1:0]        WARM_ONE  = WW'(1);
  localparam logic signed [32:0]   HYST_S    = 33'(HYST);

  logic                  ir_valid_s, red_valid_s;
  logic [DATA_WIDTH-1:0] ir_avg_s, red_avg_s;

  ppg_moving_avg #(.DATA_WIDTH(DATA_WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg_ir (
    .clk(clk), .rst(rst), .in_valid(sample_valid), .in_data(raw_ir),
    .out_valid(ir_valid_s), .out_data(ir_avg_s)
  );

  ppg_moving_avg #(.DATA_WIDTH(DATA_WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg_red (
    .clk(clk), .rst(rst), .in_valid(sample_valid), .in_data(raw_red),
    .out_valid(red_valid_s), .out_data(red_avg_s)
  );

  assign new_sample   = ir_valid_s & red_valid_s;
  assign filtered_ir  = ir_avg_s;
  assign filtered_red = red_avg_s;

  ppg_state_t            state_r, state_nxt_s;
  logic [DATA_WIDTH-1:0] cand_r, cand_nxt_s;
  logic [DATA_WIDTH-1:0] trough_r, trough_nxt_s;
  logic [WW-1:0]         warm_cnt_r, warm_nxt_s;
  logic [RW-1:0]         refr_cnt_r, refr_nxt_s, refr_inc_s;
  logic                  peak_nxt_s;
  logic [DATA_WIDTH-1:0] peak_value_nxt_s;
  logic signed [32:0]    drop_s, lift_s;

  // Swings relative to the running candidate peak and trough
  always_comb begin
    drop_s = ppg_sdiff(32'(cand_r), 32'(ir_avg_s));
    lift_s = ppg_sdiff(32'(ir_avg_s), 32'(trough_r));
  end

  // Detector next-state, refractory counter and peak strobe
  always_comb begin
    state_nxt_s      = state_r;
    cand_nxt_s       = cand_r;
    trough_nxt_s     = trough_r;
    warm_nxt_s       = warm_cnt_r;
    refr_nxt_s       = refr_cnt_r;
    peak_nxt_s       = 1'b0;
    peak_value_nxt_s = peak_value;
    if (refr_cnt_r >= REFR_MAX) begin
      refr_inc_s = REFR_MAX;
    end else begin
      refr_inc_s = refr_cnt_r + REFR_ONE;
    end
    if (new_sample) begin
      refr_nxt_s = refr_inc_s;
      case (state_r)
        ST_WARMUP: begin
          if (warm_cnt_r == WARM_LAST) begin
            cand_nxt_s  = ir_avg_s;
            state_nxt_s = ST_RISING;
          end else begin
            warm_nxt_s = warm_cnt_r + WARM_ONE;
          end
        end
        ST_RISING: begin
          if (drop_s < 33'sd0) begin
            cand_nxt_s = ir_avg_s;
          end else if (drop_s >= HYST_S) begin
            trough_nxt_s = ir_avg_s;
            state_nxt_s  = ST_FALLING;
            // a fall inside the refractory window changes state silently
            if (refr_cnt_r >= REFR_MAX) begin
              peak_nxt_s       = 1'b1;
              peak_value_nxt_s = cand_r;
              refr_nxt_s       = '0;
            end else begin
              peak_nxt_s = 1'b0;
            end
          end else begin
            cand_nxt_s = cand_r;
          end
        end
        ST_FALLING: begin
          if (lift_s < 33'sd0) begin
            trough_nxt_s = ir_avg_s;
          end else if (lift_s >= HYST_S) begin
            cand_nxt_s  = ir_avg_s;
            state_nxt_s = ST_RISING;
          end else begin
            trough_nxt_s = trough_r;
          end
        end
        default: begin
          state_nxt_s = ST_WARMUP;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Detector state and registered peak outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_WARMUP;
      cand_r        <= '0;
      trough_r      <= '0;
      warm_cnt_r    <= '0;
      refr_cnt_r    <= '0;
      peak_detected <= 1'b0;
      peak_value    <= '0;
    end else begin
      state_r       <= state_nxt_s;
      cand_r        <= cand_nxt_s;
      trough_r      <= trough_nxt_s;
      warm_cnt_r    <= warm_nxt_s;
      refr_cnt_r    <= refr_nxt_s;
      peak_detected <= peak_nxt_s;
      peak_value    <= peak_value_nxt_s;
    end
  end

endmodule

// File: tb/tb_ppg_peak_detector.sv
// Directed and randomized bench for ppg_peak_detector against a windowed-mean
// and peak-rule reference model.
module tb_ppg_peak_detector;

  localparam int DEPTH = 4;
  localparam int HYST  = 16;
  localparam int REFR  = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] raw_ir = 16'd0;
  logic [15:0] raw_red = 16'd0;
  logic        new_sample, peak_detected;
  logic [15:0] filtered_ir, filtered_red, peak_value;

  ppg_peak_detector #(
    .DATA_WIDTH(16), .AVG_LOG2(2), .HYST(HYST), .REFRACT_SAMPLES(REFR)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .raw_ir(raw_ir), .raw_red(raw_red),
    .new_sample(new_sample), .filtered_ir(filtered_ir),
    .filtered_red(filtered_red), .peak_detected(peak_detected),
    .peak_value(peak_value)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef enum {P_WARM, P_RISE, P_FALL} phase_t;
  int     win_ir[$];
  int     win_red[$];
  phase_t m_phase;
  int     m_seen, m_cand, m_trough, m_refr, m_pv, m_fir, m_fred;
  bit     m_pend;
  int     dut_peaks = 0;
  int     model_peaks = 0;

  function automatic int mean(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / DEPTH;
  endfunction

  task automatic model_reset();
    win_ir = {};
    win_red = {};
    for (int i = 0; i < DEPTH; i++) begin
      win_ir.push_back(0);
      win_red.push_back(0);
    end
    m_phase = P_WARM;
    m_seen = 0; m_cand = 0; m_trough = 0; m_refr = 0; m_pv = 0;
    m_fir = 0; m_fred = 0; m_pend = 1'b0;
  endtask

  task automatic model_push(input int ir, input int red);
    int  f;
    bit  acc;
    acc = 1'b0;
    win_ir.push_back(ir);
    void'(win_ir.pop_front());
    win_red.push_back(red);
    void'(win_red.pop_front());
    m_fir  = mean(win_ir);
    m_fred = mean(win_red);
    f = m_fir;
    m_seen++;
    if (m_phase == P_WARM) begin
      if (m_seen == DEPTH) begin
        m_cand = f;
        m_phase = P_RISE;
      end
    end else if (m_phase == P_RISE) begin
      if (f > m_cand) m_cand = f;
      else if (m_cand - f >= HYST) begin
        m_trough = f;
        m_phase = P_FALL;
        if (m_refr >= REFR) begin
          acc = 1'b1;
          m_pv = m_cand;
        end
      end
    end else begin
      if (f < m_trough) m_trough = f;
      else if (f - m_trough >= HYST) begin
        m_cand = f;
        m_phase = P_RISE;
      end
    end
    m_refr = acc ? 0 : ((m_refr + 1 > REFR) ? REFR : m_refr + 1);
    m_pend = acc;
    if (acc) model_peaks++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: optionally present a sample, then check the registered outputs
  task automatic step(input bit v, input int ir, input int red);
    @(negedge clk);
    sample_valid = v;
    raw_ir = 16'(ir);
    raw_red = 16'(red);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    chk("peak_detected", {31'd0, peak_detected}, {31'd0, m_pend});
    chk("peak_value", {16'd0, peak_value}, m_pv);
    if (peak_detected) dut_peaks++;
    m_pend = 1'b0;
    if (v) model_push(ir, red);
    chk("new_sample", {31'd0, new_sample}, {31'd0, v});
    chk("filtered_ir", {16'd0, filtered_ir}, m_fir);
    chk("filtered_red", {16'd0, filtered_red}, m_fred);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bump_seq(input int gap);
    repeat (40) step(1'b1, 1000, 800);
    repeat (4) step(1'b1, 1100, 800);
    repeat (gap) step(1'b1, 1000, 800);
    repeat (4) step(1'b1, 1100, 800);
    repeat (10) step(1'b1, 1000, 800);
    step(1'b0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ramp_exp[4];
    int p0, m0, ir, ph, pk;
    ramp_exp = '{250, 500, 750, 1000};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_new_sample", {31'd0, new_sample}, 32'd0);
    chk("rst_filtered_ir", {16'd0, filtered_ir}, 32'd0);
    chk("rst_peak", {31'd0, peak_detected}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    repeat (100) step(1'b0, 0, 0);

    // filter ramp with idle gaps
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1000, 500);
      chk("ramp_ir", {16'd0, filtered_ir}, (i < 4) ? ramp_exp[i] : 1000);
      step(1'b0, 0, 0);
    end
    chk("ramp_peaks", dut_peaks, 32'd0);

    // single peak with a plateau at 1200
    repeat (40) step(1'b1, 1000, 600);
    p0 = dut_peaks;
    for (int v = 1020; v <= 1200; v += 20) step(1'b1, v, 600);
    repeat (3) step(1'b1, 1200, 600);
    for (int v = 1180; v >= 1000; v -= 20) step(1'b1, v, 600);
    repeat (6) step(1'b1, 1000, 600);
    step(1'b0, 0, 0);
    chk("single_count", dut_peaks - p0, 32'd1);
    chk("single_value", {16'd0, peak_value}, 32'd1200);

    // +-10 alternating ripple stays inside the hysteresis band
    p0 = dut_peaks;
    for (int i = 0; i < 64; i++) step(1'b1, (i % 2) ? 990 : 1010, 700);
    step(1'b0, 0, 0);
    chk("ripple10_count", dut_peaks - p0, 32'd0);

    // +-20 square ripple, random phase: peaks limited by refractory spacing
    p0 = dut_peaks;
    m0 = model_peaks;
    ph = $urandom_range(0, 7);
    for (int i = 0; i < 96; i++) step(1'b1, (((i + ph) / 4) % 2) ? 980 : 1020, 700);
    step(1'b0, 0, 0);
    chk("ripple20_count", dut_peaks - p0, model_peaks - m0);
    chk("ripple20_some", {31'd0, (dut_peaks - p0) >= 2}, 32'd1);

    // refractory: second bump 10 samples later is suppressed
    do_reset();
    p0 = dut_peaks;
    bump_seq(6);
    chk("refr_close", dut_peaks - p0, 32'd1);

    // refractory: second bump 35 samples later is accepted
    do_reset();
    p0 = dut_peaks;
    bump_seq(31);
    chk("refr_far", dut_peaks - p0, 32'd2);

    // back-to-back sine, amplitude 500, period 64
    p0 = dut_peaks;
    m0 = model_peaks;
    ph = $urandom_range(0, 63);
    for (int k = 0; k < 256; k++) begin
      ir = 1000 + $rtoi(500.0 * $sin(2.0 * 3.14159265358979 * real'(k + ph) / 64.0) + 500.0) - 500;
      step(1'b1, ir, 2000 - (ir / 2));
    end
    step(1'b0, 0, 0);
    pk = dut_peaks - p0;
    chk("sine_count", pk, model_peaks - m0);
    chk("sine_rate", {31'd0, (pk >= 3) && (pk <= 5)}, 32'd1);

    // random walk with random valid gaps
    ir = 1500;
    for (int i = 0; i < 300; i++) begin
      ir = ir + $urandom_range(0, 80) - 40;
      if (ir < 500) ir = 500;
      if (ir > 4000) ir = 4000;
      step(1'($urandom_range(0, 1)), ir, $urandom_range(0, 4000));
    end
    step(1'b0, 0, 0);

    // asynchronous reset between edges with a sample in flight
    @(negedge clk);
    sample_valid = 1'b1;
    raw_ir = 16'd3000;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_filtered_ir", {16'd0, filtered_ir}, 32'd0);
    chk("arst_filtered_red", {16'd0, filtered_red}, 32'd0);
    chk("arst_peak_value", {16'd0, peak_value}, 32'd0);
    chk("arst_new_sample", {31'd0, new_sample}, 32'd0);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 0, 0);
    p0 = dut_peaks;
    bump_seq(31);
    chk("post_rst_peaks", dut_peaks - p0, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
